// File: rtl/tiny_dnn_pkg.sv
// Shared types and field widths for the tiny_dnn convolution address sequencer.
// The BIAS state exists only when TINY_DNN_SEQ_BIAS_EN is defined.
package tiny_dnn_pkg;
    localparam int ID_W  = 4;
    localparam int IS_W  = 10;
    localparam int DIM_W = 5;
    localparam int K_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef TINY_DNN_SEQ_BIAS_EN
        BIAS = 2'd2,
`endif
        FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/tiny_dnn_cnt.sv
// Single wrap counter: counts 0..limit-1 on inc, pulses wrap when it rolls over.
module tiny_dnn_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         wrap
);
    // Widen by one bit so limit==0 never aliases to the all-ones value.
    assign at_max = ((W+1)'(cnt) + (W+1)'(1)) == (W+1)'(limit);
    assign wrap   = inc & at_max;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc)
            cnt <= at_max ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/tiny_dnn_seq.sv
// Convolution beat sequencer: walks oy/ox/ic/ky/kx and emits buffer addresses per beat.
// Define TINY_DNN_SEQ_BIAS_EN to add an optional bias beat after each accumulation.
module tiny_dnn_seq
    import tiny_dnn_pkg::*;
#(
    parameter int IAW = 12,
    parameter int WAW = 10,
    parameter int OAW = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             enbias,
    input  logic [ID_W-1:0]  id,
    input  logic [IS_W-1:0]  is,
    input  logic [DIM_W-1:0] iw,
    input  logic [DIM_W-1:0] oh,
    input  logic [DIM_W-1:0] ow,
    input  logic [DIM_W-1:0] ks,
    input  logic [K_W-1:0]   kh,
    input  logic [K_W-1:0]   kw,
    output logic [IAW-1:0]   in_addr,
    output logic [WAW-1:0]   w_addr,
    output logic [OAW-1:0]   out_addr,
    output logic             src_valid,
    input  logic             src_ready,
    output logic             first,
    output logic             last,
    output logic             bias,
    output logic             busy,
    output logic             done
);
    state_t state, nxt;
    logic   run_q, start, clr, adv, bias_on;
    logic   zero_dim, acc_end, final_beat;

    logic [K_W-1:0]   kx, ky;
    logic [ID_W-1:0]  ic;
    logic [DIM_W-1:0] ox, oy;
    logic kx_max, ky_max, ic_max, ox_max, oy_max;
    logic kx_wrap, ky_wrap, ic_wrap, ox_wrap, unused_oy_wrap;

`ifdef TINY_DNN_SEQ_BIAS_EN
    assign bias_on = enbias;
`else
    logic unused_enbias;
    assign unused_enbias = enbias;
    assign bias_on       = 1'b0;
`endif

    // Innermost first: each counter steps when the one inside it wraps.
    tiny_dnn_cnt #(.W(K_W))   u_kx (.clk(clk), .reset(reset), .clr(clr), .inc(adv),     .limit(kw), .cnt(kx), .at_max(kx_max), .wrap(kx_wrap));
    tiny_dnn_cnt #(.W(K_W))   u_ky (.clk(clk), .reset(reset), .clr(clr), .inc(kx_wrap), .limit(kh), .cnt(ky), .at_max(ky_max), .wrap(ky_wrap));
    tiny_dnn_cnt #(.W(ID_W))  u_ic (.clk(clk), .reset(reset), .clr(clr), .inc(ky_wrap), .limit(id), .cnt(ic), .at_max(ic_max), .wrap(ic_wrap));
    tiny_dnn_cnt #(.W(DIM_W)) u_ox (.clk(clk), .reset(reset), .clr(clr), .inc(ic_wrap), .limit(ow), .cnt(ox), .at_max(ox_max), .wrap(ox_wrap));
    tiny_dnn_cnt #(.W(DIM_W)) u_oy (.clk(clk), .reset(reset), .clr(clr), .inc(ox_wrap), .limit(oh), .cnt(oy), .at_max(oy_max), .wrap(unused_oy_wrap));

    assign start      = run & ~run_q;
    assign zero_dim   = (oh == '0) | (ow == '0) | (id == '0) | (kh == '0) | (kw == '0);
    assign acc_end    = kx_max & ky_max & ic_max;
    assign final_beat = acc_end & ox_max & oy_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            run_q <= 1'b1;
        end else begin
            state <= nxt;
            run_q <= run;
        end
    end

    always_comb begin
        nxt       = state;
        src_valid = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        bias      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        adv       = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (start) nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (zero_dim) begin
                    nxt = FIN;
                end else begin
                    src_valid = 1'b1;
                    first     = (kx == '0) & (ky == '0) & (ic == '0);
                    last      = acc_end & ~bias_on;
                    if (src_ready) begin
`ifdef TINY_DNN_SEQ_BIAS_EN
                        // Counters hold on the last data beat so the bias beat keeps in_addr.
                        if (acc_end && bias_on) begin
                            nxt = BIAS;
                        end else begin
                            adv = 1'b1;
                            if (final_beat) nxt = FIN;
                        end
`else
                        adv = 1'b1;
                        if (final_beat) nxt = FIN;
`endif
                    end
                end
            end
`ifdef TINY_DNN_SEQ_BIAS_EN
            BIAS: begin
                busy      = 1'b1;
                src_valid = 1'b1;
                bias      = 1'b1;
                last      = 1'b1;
                if (src_ready) begin
                    adv = 1'b1;
                    nxt = final_beat ? FIN : RUN;
                end
            end
`endif
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (!run && state != IDLE) begin
            nxt = IDLE;
            adv = 1'b0;
            clr = 1'b1;
        end
    end

    assign in_addr  = IAW'(32'(ic) * 32'(is) + (32'(oy) + 32'(ky)) * 32'(iw) + 32'(ox) + 32'(kx));
    assign w_addr   = bias ? WAW'(32'(id) * 32'(ks))
                           : WAW'(32'(ic) * 32'(ks) + 32'(ky) * 32'(kw) + 32'(kx));
    assign out_addr = OAW'(32'(oy) * 32'(ow) + 32'(ox));
endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Self-checking bench for tiny_dnn_seq against a loop-nest reference model.
module tb_tiny_dnn_seq;
    logic       clk = 0, reset = 1, run = 0, enbias = 0, src_ready = 0;
    logic [3:0] id;
    logic [9:0] is;
    logic [4:0] iw, oh, ow, ks;
    logic [2:0] kh, kw;
    logic [11:0] in_addr;
    logic [9:0]  w_addr, out_addr;
    logic src_valid, first, last, bias, busy, done;

    typedef struct packed {
        logic [11:0] in_a;
        logic [9:0]  w_a;
        logic [9:0]  o_a;
        logic f, l, b;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int total = 0, bad = 0;

    tiny_dnn_seq dut (
        .clk(clk), .reset(reset), .run(run), .enbias(enbias),
        .id(id), .is(is), .iw(iw), .oh(oh), .ow(ow), .ks(ks), .kh(kh), .kw(kw),
        .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
        .src_valid(src_valid), .src_ready(src_ready),
        .first(first), .last(last), .bias(bias), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t cur_beat();
        return {in_addr, w_addr, out_addr, first, last, bias};
    endfunction

    // Reference: the loop nest written out directly, one entry per beat.
    function automatic void build_model();
        bit ben;
        beat_t bt;
        int lin;
`ifdef TINY_DNN_SEQ_BIAS_EN
        ben = enbias;
`else
        ben = 0;
`endif
        exp_q.delete();
        for (int y = 0; y < int'(oh); y++)
            for (int x = 0; x < int'(ow); x++) begin
                lin = 0;
                for (int c = 0; c < int'(id); c++)
                    for (int r = 0; r < int'(kh); r++)
                        for (int s = 0; s < int'(kw); s++) begin
                            lin     = c * int'(is) + (y + r) * int'(iw) + x + s;
                            bt.in_a = 12'(lin);
                            bt.w_a  = 10'(c * int'(ks) + r * int'(kw) + s);
                            bt.o_a  = 10'(y * int'(ow) + x);
                            bt.f    = (c == 0 && r == 0 && s == 0);
                            bt.l    = !ben && (c == int'(id) - 1 && r == int'(kh) - 1 && s == int'(kw) - 1);
                            bt.b    = 0;
                            exp_q.push_back(bt);
                        end
                if (ben) begin
                    bt.in_a = 12'(lin);
                    bt.w_a  = 10'(int'(id) * int'(ks));
                    bt.o_a  = 10'(y * int'(ow) + x);
                    bt.f = 0; bt.l = 1; bt.b = 1;
                    exp_q.push_back(bt);
                end
            end
    endfunction

    task automatic set_basic();
        id = 1; iw = 4; oh = 2; ow = 2; kh = 3; kw = 3; ks = 9; is = 16; enbias = 0;
    endtask

    // mode 0: always ready, 1: ready toggles 1,0, 2: random ready
    task automatic run_seq(input int abort_after, input int mode);
        int idx = 0, cyc = 0;
        bit stalled = 0;
        beat_t held, cur;
        build_model();
        obs_q.delete();
        run = 1;
        step();
        while (idx < exp_q.size() && cyc < 5000) begin
            if (abort_after > 0 && idx == abort_after) begin
                run = 0; src_ready = 0;
                step();
                total++;
                if ({src_valid, busy, done} !== 3'b000) begin
                    bad++; $display("FAIL abort_idle got v/b/d=%b want 000", {src_valid, busy, done});
                end
                for (int k = 0; k < 3; k++) begin
                    step();
                    total++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        bad++; $display("FAIL abort_no_done got d=%b b=%b want 0 0", done, busy);
                    end
                end
                return;
            end
            src_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            cur = cur_beat();
            total++;
            if ({src_valid, busy, done} !== 3'b110) begin
                bad++; $display("FAIL beat_status idx=%0d got v/b/d=%b want 110", idx, {src_valid, busy, done});
            end
            if (stalled) begin
                total++;
                if (cur !== held) begin
                    bad++; $display("FAIL stall_stable idx=%0d got %h want %h", idx, cur, held);
                end
            end
            if (src_ready) begin
                total++;
                if (cur !== exp_q[idx]) begin
                    bad++; $display("FAIL beat idx=%0d got %h want %h", idx, cur, exp_q[idx]);
                end
                obs_q.push_back(cur);
                idx++;
                stalled = 0;
            end else begin
                held = cur;
                stalled = 1;
            end
            step();
            cyc++;
        end
        src_ready = 0;
        total++;
        if (cyc >= 5000) begin
            bad++; $display("FAIL timeout beats got %0d want %0d", idx, exp_q.size());
        end
        total++;
        if ({src_valid, busy, done} !== 3'b011) begin
            bad++; $display("FAIL fin got v/b/d=%b want 011", {src_valid, busy, done});
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({src_valid, busy, done} !== 3'b000) begin
                bad++; $display("FAIL after_done got v/b/d=%b want 000", {src_valid, busy, done});
            end
        end
        run = 0;
        step();
    endtask

    task automatic test_reset();
        set_basic();
        reset = 1; run = 1; src_ready = 1;
        repeat (2) step();
        total++;
        if ({cur_beat(), src_valid, busy, done} !== '0) begin
            bad++; $display("FAIL reset_state got %h want 0", {cur_beat(), src_valid, busy, done});
        end
        reset = 0;
        repeat (3) step();
        total++;
        if ({src_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL run_high_at_release got v/b=%b want 00", {src_valid, busy});
        end
        run = 0;
        step();
        run_seq(0, 0);
        // reset in the middle of a handshake, run still high
        run = 1; src_ready = 1;
        repeat (4) step();
        reset = 1;
        step();
        total++;
        if ({cur_beat(), src_valid, busy, done} !== '0) begin
            bad++; $display("FAIL reset_midrun got %h want 0", {cur_beat(), src_valid, busy, done});
        end
        reset = 0;
        repeat (2) step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL no_restart_after_reset got busy=%b want 0", busy);
        end
        run = 0; src_ready = 0;
        step();
    endtask

    task automatic test_basic();
        set_basic();
        run_seq(0, 0);
        total++;
        if (obs_q.size() != 36) begin
            bad++; $display("FAIL basic_count got %0d want 36", obs_q.size());
        end else begin
            total++;
            if ({obs_q[0].in_a, obs_q[0].w_a, obs_q[0].o_a} !== '0 || obs_q[9].in_a !== 12'd1) begin
                bad++; $display("FAIL basic_addr got b0=%h b9in=%0d want 0 and 1", obs_q[0], obs_q[9].in_a);
            end
            for (int k = 0; k < 36; k++) begin
                total++;
                if (obs_q[k].l !== ((k % 9) == 8)) begin
                    bad++; $display("FAIL basic_last beat=%0d got %b want %b", k, obs_q[k].l, (k % 9) == 8);
                end
            end
        end
    endtask

    task automatic test_stall();
        set_basic();
        run_seq(0, 1);
    endtask

    task automatic test_zero();
        for (int z = 0; z < 5; z++) begin
            set_basic();
            case (z)
                0: kh = 0;
                1: kw = 0;
                2: id = 0;
                3: oh = 0;
                default: ow = 0;
            endcase
            src_ready = 1; run = 1;
            step();
            total++;
            if ({src_valid, busy, done} !== 3'b010) begin
                bad++; $display("FAIL zero_c1 z=%0d got v/b/d=%b want 010", z, {src_valid, busy, done});
            end
            step();
            total++;
            if ({src_valid, busy, done} !== 3'b011) begin
                bad++; $display("FAIL zero_c2 z=%0d got v/b/d=%b want 011", z, {src_valid, busy, done});
            end
            step();
            total++;
            if ({src_valid, busy, done} !== 3'b000) begin
                bad++; $display("FAIL zero_c3 z=%0d got v/b/d=%b want 000", z, {src_valid, busy, done});
            end
            run = 0; src_ready = 0;
            step();
        end
    endtask

    task automatic test_abort();
        set_basic();
        run_seq(5, 0);
        run_seq(0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            id = 4'($urandom_range(1, 3)); kh = 3'($urandom_range(1, 3)); kw = 3'($urandom_range(1, 3));
            oh = 5'($urandom_range(1, 3)); ow = 5'($urandom_range(1, 3));
            iw = 5'($urandom_range(1, 31)); is = 10'($urandom_range(0, 1023));
            ks = 5'(kh * kw); enbias = 1'($urandom_range(0, 1));
            run_seq(0, 2);
        end
    endtask

`ifdef TINY_DNN_SEQ_BIAS_EN
    task automatic test_bias();
        set_basic();
        id = 2; enbias = 1;
        run_seq(0, 0);
        total++;
        if (obs_q.size() != 76) begin
            bad++; $display("FAIL bias_count got %0d want 76", obs_q.size());
        end else begin
            total++;
            if (obs_q[18].b !== 1'b1 || obs_q[18].w_a !== 10'd18 || obs_q[17].l !== 1'b0) begin
                bad++; $display("FAIL bias_beat got b=%b w=%0d l17=%b want 1 18 0",
                                obs_q[18].b, obs_q[18].w_a, obs_q[17].l);
            end
        end
        enbias = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_abort();
`ifdef TINY_DNN_SEQ_BIAS_EN
        test_bias();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
